// File: rtl/drone_mission_ctrl_if.sv
// Command/sensor inputs and status outputs of the rescue-drone mission controller.
interface drone_mission_ctrl_if #(
  parameter int unsigned ALT_W = 8,
  parameter int unsigned BAT_W = 8,
  parameter int unsigned CNT_W = 8
);
  logic [1:0]       cmd;
  logic             sensor_ok;
  logic             err;
  logic [ALT_W-1:0] altitude;
  logic [BAT_W-1:0] battery;
  logic             thermal_found;
  logic             man_ctrl;
  logic             img_valid;
  logic             img_pass;
  logic             landed;
  logic [3:0]       state;
  logic             capture_req;
  logic [CNT_W-1:0] target_count;
  logic [2:0]       fault_code;
  logic [1:0]       retry_cnt;

  modport master (
    output cmd, sensor_ok, err, altitude, battery, thermal_found, man_ctrl,
           img_valid, img_pass, landed,
    input  state, capture_req, target_count, fault_code, retry_cnt
  );

  modport slave (
    input  cmd, sensor_ok, err, altitude, battery, thermal_found, man_ctrl,
           img_valid, img_pass, landed,
    output state, capture_req, target_count, fault_code, retry_cnt
  );
endinterface

// File: rtl/drone_mission_ctrl.sv
// Second-generation rescue-drone mission FSM: per-state timeouts, capture retries,
// low-battery return, latched fault code and saturating rescued-target counter.
module drone_mission_ctrl #(
  parameter int unsigned ALT_W       = 8,
  parameter int unsigned BAT_W       = 8,
  parameter int unsigned TMR_W       = 16,
  parameter int unsigned TAKEOFF_ALT = 50,
  parameter int unsigned BAT_LOW     = 20,
  parameter int unsigned INIT_TMO    = 100,
  parameter int unsigned TAKEOFF_TMO = 2000,
  parameter int unsigned SEARCH_TMO  = 50000,
  parameter int unsigned CAP_TMO     = 1000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CNT_W       = 8
) (
  input logic               clk,
  input logic               reset,
  drone_mission_ctrl_if.slave bus
);
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_INIT    = 4'd1;
  localparam logic [3:0] S_FAIL    = 4'd2;
  localparam logic [3:0] S_TAKEOFF = 4'd3;
  localparam logic [3:0] S_SEARCH  = 4'd4;
  localparam logic [3:0] S_CAPTURE = 4'd5;
  localparam logic [3:0] S_RETURN  = 4'd6;
  localparam logic [3:0] S_MANUAL  = 4'd7;
  localparam logic [3:0] S_TARGET  = 4'd8;
  localparam logic [3:0] S_MAINT   = 4'd9;

  localparam logic [TMR_W-1:0] INIT_LAST    = TMR_W'(INIT_TMO - 1);
  localparam logic [TMR_W-1:0] TAKEOFF_LAST = TMR_W'(TAKEOFF_TMO - 1);
  localparam logic [TMR_W-1:0] SEARCH_LAST  = TMR_W'(SEARCH_TMO - 1);
  localparam logic [TMR_W-1:0] CAP_LAST     = TMR_W'(CAP_TMO - 1);
  localparam logic [TMR_W-1:0] TMR_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [ALT_W-1:0] ALT_THR      = ALT_W'(TAKEOFF_ALT);
  localparam logic [BAT_W-1:0] BAT_THR      = BAT_W'(BAT_LOW);

  logic [3:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q;
  logic [2:0]       fault_q, fault_d;
  logic [1:0]       retry_q, retry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             capreq_q;
  logic             restart;
  logic             airborne, bat_low, abort_req;

  assign airborne  = (state_q == S_TAKEOFF) || (state_q == S_SEARCH) ||
                     (state_q == S_TARGET)  || (state_q == S_CAPTURE) ||
                     (state_q == S_MANUAL)  || (state_q == S_RETURN);
  assign bat_low   = bus.battery < BAT_THR;
  assign abort_req = bus.cmd == 2'b10;

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    retry_d = retry_q;
    count_d = count_q;
    restart = 1'b0;
    if (airborne && bus.err) begin
      state_d = S_FAIL;
      fault_d = 3'd3;
    end else if (airborne && state_q != S_RETURN && (bat_low || abort_req)) begin
      state_d = S_RETURN;
      if (bat_low && fault_q == '0) fault_d = 3'd4;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd == 2'b01)      state_d = S_INIT;
          else if (bus.cmd == 2'b11) state_d = S_MAINT;
        end
        S_INIT: begin
          if (bus.sensor_ok) state_d = S_TAKEOFF;
          else if (bus.err || timer_q == INIT_LAST) begin
            state_d = S_FAIL;
            fault_d = 3'd1;
          end
        end
        S_TAKEOFF: begin
          if (bus.altitude > ALT_THR) state_d = S_SEARCH;
          else if (timer_q == TAKEOFF_LAST) begin
            state_d = S_FAIL;
            fault_d = 3'd2;
          end
        end
        S_SEARCH: begin
          if (bus.thermal_found)       state_d = S_TARGET;
          else if (bus.man_ctrl)       state_d = S_MANUAL;
          else if (timer_q == SEARCH_LAST) state_d = S_RETURN;
        end
        S_TARGET: begin
          if (bus.thermal_found) begin
            state_d = S_CAPTURE;
            retry_d = '0;
          end else begin
            state_d = S_SEARCH;
          end
        end
        S_CAPTURE: begin
          // img_valid is tested before the timeout so a coincident result wins
          if (bus.img_valid && bus.img_pass) begin
            if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
            state_d = S_SEARCH;
          end else if (bus.img_valid || timer_q == CAP_LAST) begin
            if ((32'(retry_q) + 32'd1) < MAX_RETRY) begin
              retry_d = retry_q + 2'd1;
              restart = 1'b1;
            end else begin
              state_d = S_SEARCH;
            end
          end
        end
        S_MANUAL: begin
          if (!bus.man_ctrl)         state_d = S_SEARCH;
          else if (bus.cmd == 2'b11) state_d = S_MAINT;
        end
        S_RETURN: begin
          if (bus.landed) begin
            state_d = S_IDLE;
            if (fault_q == 3'd4) fault_d = '0;
          end
        end
        S_FAIL: begin
          if (bus.cmd == 2'b01) state_d = S_MAINT;
        end
        S_MAINT: begin
          if (bus.man_ctrl) state_d = S_MANUAL;
          else if (!bus.err) begin
            state_d = S_IDLE;
            fault_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      fault_q  <= '0;
      retry_q  <= '0;
      count_q  <= '0;
      capreq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      retry_q <= retry_d;
      count_q <= count_d;
      if (state_d != state_q || restart) timer_q <= '0;
      else if (timer_q != TMR_MAX)       timer_q <= timer_q + TMR_W'(1);
      // registered trigger lines up with the timer==0 cycle of each attempt
      capreq_q <= (state_d == S_CAPTURE) && (state_q != S_CAPTURE || restart);
    end
  end

  assign bus.state        = state_q;
  assign bus.capture_req  = capreq_q;
  assign bus.target_count = count_q;
  assign bus.fault_code   = fault_q;
  assign bus.retry_cnt    = retry_q;
endmodule

// File: tb/tb_drone_mission_ctrl.sv
// Directed-vector bench for drone_mission_ctrl: stimulus table plus multi-cycle sequences.
module tb_drone_mission_ctrl;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   exp_count;

  drone_mission_ctrl_if #(.ALT_W(8), .BAT_W(8), .CNT_W(8)) bus ();

  drone_mission_ctrl #(
    .ALT_W(8), .BAT_W(8), .TMR_W(16), .TAKEOFF_ALT(50), .BAT_LOW(20),
    .INIT_TMO(100), .TAKEOFF_TMO(2000), .SEARCH_TMO(50000), .CAP_TMO(1000),
    .MAX_RETRY(3), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cmd;
    logic       sok, err;
    logic [7:0] alt, bat;
    logic       thr, man, iv, ip, lnd;
    logic [3:0] st;
    logic       cr;
    logic [7:0] cnt;
    logic [2:0] flt;
    logic [1:0] rty;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic [1:0] cmd, input logic sok, input logic err,
                              input logic [7:0] alt, input logic [7:0] bat,
                              input logic thr, input logic man, input logic iv,
                              input logic ip, input logic lnd,
                              input logic [3:0] st, input logic cr, input logic [7:0] cnt,
                              input logic [2:0] flt, input logic [1:0] rty);
    vec_t v;
    v.cmd = cmd; v.sok = sok; v.err = err; v.alt = alt; v.bat = bat;
    v.thr = thr; v.man = man; v.iv = iv; v.ip = ip; v.lnd = lnd;
    v.st = st; v.cr = cr; v.cnt = cnt; v.flt = flt; v.rty = rty;
    return v;
  endfunction

  task automatic set_idle();
    bus.cmd = 2'b00; bus.sensor_ok = 1'b0; bus.err = 1'b0; bus.altitude = 8'd10;
    bus.battery = 8'd100; bus.thermal_found = 1'b0; bus.man_ctrl = 1'b0;
    bus.img_valid = 1'b0; bus.img_pass = 1'b0; bus.landed = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic goto_search(input int idx);
    bus.cmd = 2'b01; step();
    bus.cmd = 2'b00; bus.sensor_ok = 1'b1; step();
    bus.sensor_ok = 1'b0; bus.altitude = 8'd60; step();
    bus.altitude = 8'd10;
    check("goto_search", idx, 32'(bus.state), 32'd4);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //             cmd  sok err alt    bat    thr man iv ip lnd  st  cr cnt flt rty
    vecs[0]  = mk(2'd1, 0, 0, 8'd10, 8'd100, 0, 0, 0, 0, 0, 4'd1, 0, 8'd0, 3'd0, 2'd0);
    vecs[1]  = mk(2'd0, 1, 0, 8'd10, 8'd100, 0, 0, 0, 0, 0, 4'd3, 0, 8'd0, 3'd0, 2'd0);
    vecs[2]  = mk(2'd0, 0, 0, 8'd50, 8'd100, 0, 0, 0, 0, 0, 4'd3, 0, 8'd0, 3'd0, 2'd0);
    vecs[3]  = mk(2'd0, 0, 0, 8'd51, 8'd100, 0, 0, 0, 0, 0, 4'd4, 0, 8'd0, 3'd0, 2'd0);
    vecs[4]  = mk(2'd0, 0, 0, 8'd51, 8'd100, 1, 0, 0, 0, 0, 4'd8, 0, 8'd0, 3'd0, 2'd0);
    vecs[5]  = mk(2'd0, 0, 0, 8'd51, 8'd100, 1, 0, 0, 0, 0, 4'd5, 1, 8'd0, 3'd0, 2'd0);
    vecs[6]  = mk(2'd0, 0, 0, 8'd51, 8'd100, 0, 0, 0, 0, 0, 4'd5, 0, 8'd0, 3'd0, 2'd0);
    vecs[7]  = mk(2'd0, 0, 0, 8'd51, 8'd100, 0, 0, 0, 0, 0, 4'd5, 0, 8'd0, 3'd0, 2'd0);
    vecs[8]  = mk(2'd0, 0, 0, 8'd51, 8'd100, 0, 0, 1, 1, 0, 4'd4, 0, 8'd1, 3'd0, 2'd0);
    vecs[9]  = mk(2'd0, 0, 0, 8'd51, 8'd100, 0, 0, 0, 0, 0, 4'd4, 0, 8'd1, 3'd0, 2'd0);
    vecs[10] = mk(2'd0, 0, 0, 8'd51, 8'd100, 1, 0, 0, 0, 0, 4'd8, 0, 8'd1, 3'd0, 2'd0);
    vecs[11] = mk(2'd0, 0, 0, 8'd51, 8'd100, 1, 0, 0, 0, 0, 4'd5, 1, 8'd1, 3'd0, 2'd0);
    vecs[12] = mk(2'd0, 0, 0, 8'd51, 8'd100, 0, 0, 1, 0, 0, 4'd5, 1, 8'd1, 3'd0, 2'd1);
    vecs[13] = mk(2'd0, 0, 0, 8'd51, 8'd100, 0, 0, 0, 0, 0, 4'd5, 0, 8'd1, 3'd0, 2'd1);
    vecs[14] = mk(2'd0, 0, 0, 8'd51, 8'd100, 0, 0, 1, 0, 0, 4'd5, 1, 8'd1, 3'd0, 2'd2);
    vecs[15] = mk(2'd0, 0, 0, 8'd51, 8'd100, 0, 0, 1, 0, 0, 4'd4, 0, 8'd1, 3'd0, 2'd2);
    vecs[16] = mk(2'd0, 0, 0, 8'd51, 8'd19,  0, 0, 0, 0, 0, 4'd6, 0, 8'd1, 3'd4, 2'd2);
    vecs[17] = mk(2'd2, 0, 0, 8'd51, 8'd19,  0, 0, 0, 0, 0, 4'd6, 0, 8'd1, 3'd4, 2'd2);
    vecs[18] = mk(2'd0, 0, 0, 8'd0,  8'd100, 0, 0, 0, 0, 1, 4'd0, 0, 8'd1, 3'd0, 2'd2);
    vecs[19] = mk(2'd3, 0, 0, 8'd0,  8'd100, 0, 0, 0, 0, 0, 4'd9, 0, 8'd1, 3'd0, 2'd2);
    vecs[20] = mk(2'd0, 0, 1, 8'd0,  8'd100, 0, 0, 0, 0, 0, 4'd9, 0, 8'd1, 3'd0, 2'd2);
    vecs[21] = mk(2'd0, 0, 0, 8'd0,  8'd100, 0, 0, 0, 0, 0, 4'd0, 0, 8'd1, 3'd0, 2'd2);

    reset = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_state", 0, 32'(bus.state), 32'd0);
    check("rst_capreq", 0, 32'(bus.capture_req), 32'd0);
    check("rst_count", 0, 32'(bus.target_count), 32'd0);
    check("rst_fault", 0, 32'(bus.fault_code), 32'd0);
    check("rst_retry", 0, 32'(bus.retry_cnt), 32'd0);

    // nominal mission, retries, low-battery return and maintenance
    for (int i = 0; i < 22; i++) begin
      bus.cmd = vecs[i].cmd; bus.sensor_ok = vecs[i].sok; bus.err = vecs[i].err;
      bus.altitude = vecs[i].alt; bus.battery = vecs[i].bat;
      bus.thermal_found = vecs[i].thr; bus.man_ctrl = vecs[i].man;
      bus.img_valid = vecs[i].iv; bus.img_pass = vecs[i].ip; bus.landed = vecs[i].lnd;
      step();
      check("vec_state", i, 32'(bus.state), 32'(vecs[i].st));
      check("vec_capreq", i, 32'(bus.capture_req), 32'(vecs[i].cr));
      check("vec_count", i, 32'(bus.target_count), 32'(vecs[i].cnt));
      check("vec_fault", i, 32'(bus.fault_code), 32'(vecs[i].flt));
      check("vec_retry", i, 32'(bus.retry_cnt), 32'(vecs[i].rty));
    end
    set_idle();
    exp_count = 1;

    // INIT timeout after exactly 100 cycles, then recovery through MAINT
    bus.cmd = 2'b01; step(); bus.cmd = 2'b00;
    check("init_enter", 0, 32'(bus.state), 32'd1);
    repeat (99) step();
    check("init_99", 0, 32'(bus.state), 32'd1);
    step();
    check("init_tmo_state", 0, 32'(bus.state), 32'd2);
    check("init_tmo_fault", 0, 32'(bus.fault_code), 32'd1);
    repeat (3) step();
    check("fail_hold", 0, 32'(bus.state), 32'd2);
    bus.cmd = 2'b01; step(); bus.cmd = 2'b00;
    check("rec_maint", 0, 32'(bus.state), 32'd9);
    check("rec_fault_sticky", 0, 32'(bus.fault_code), 32'd1);
    bus.err = 1'b1; step();
    check("maint_err_hold", 0, 32'(bus.state), 32'd9);
    bus.err = 1'b0; step();
    check("rec_idle", 0, 32'(bus.state), 32'd0);
    check("rec_fault_clr", 0, 32'(bus.fault_code), 32'd0);

    // TAKEOFF timeout after exactly 2000 cycles
    bus.cmd = 2'b01; step();
    bus.cmd = 2'b00; bus.sensor_ok = 1'b1; step(); bus.sensor_ok = 1'b0;
    check("to_enter", 0, 32'(bus.state), 32'd3);
    repeat (1999) step();
    check("to_1999", 0, 32'(bus.state), 32'd3);
    step();
    check("to_tmo_state", 0, 32'(bus.state), 32'd2);
    check("to_tmo_fault", 0, 32'(bus.fault_code), 32'd2);
    bus.cmd = 2'b01; step(); bus.cmd = 2'b00; step();
    check("to_rec_idle", 0, 32'(bus.state), 32'd0);

    // SEARCH timeout after exactly 50000 cycles
    goto_search(1);
    repeat (49999) step();
    check("srch_49999", 0, 32'(bus.state), 32'd4);
    step();
    check("srch_tmo_state", 0, 32'(bus.state), 32'd6);
    check("srch_tmo_fault", 0, 32'(bus.fault_code), 32'd0);
    bus.landed = 1'b1; step(); bus.landed = 1'b0;
    check("srch_land", 0, 32'(bus.state), 32'd0);

    // target_count saturates at 255
    goto_search(2);
    for (int k = 0; k < 260; k++) begin
      bus.thermal_found = 1'b1; step(); step();
      bus.thermal_found = 1'b0; bus.img_valid = 1'b1; bus.img_pass = 1'b1; step();
      bus.img_valid = 1'b0; bus.img_pass = 1'b0;
      if (exp_count < 255) exp_count++;
      check("sat_count", k, 32'(bus.target_count), 32'(exp_count));
    end
    check("sat_state", 0, 32'(bus.state), 32'd4);

    // err beats low battery and a passing image in CAPTURE
    bus.thermal_found = 1'b1; step(); step(); bus.thermal_found = 1'b0;
    check("prio_capture", 0, 32'(bus.state), 32'd5);
    bus.err = 1'b1; bus.battery = 8'd10; bus.img_valid = 1'b1; bus.img_pass = 1'b1;
    step();
    set_idle();
    check("prio_state", 0, 32'(bus.state), 32'd2);
    check("prio_fault", 0, 32'(bus.fault_code), 32'd3);
    check("prio_count", 0, 32'(bus.target_count), 32'(exp_count));
    bus.cmd = 2'b01; step(); bus.cmd = 2'b00;
    check("prio_maint_fault", 0, 32'(bus.fault_code), 32'd3);
    step();
    check("prio_idle", 0, 32'(bus.state), 32'd0);

    // asynchronous reset mid-CAPTURE
    goto_search(3);
    bus.thermal_found = 1'b1; step(); step(); bus.thermal_found = 1'b0;
    check("ar_capture", 0, 32'(bus.state), 32'd5);
    check("ar_capreq", 0, 32'(bus.capture_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_state", 0, 32'(bus.state), 32'd0);
    check("ar_capreq0", 0, 32'(bus.capture_req), 32'd0);
    check("ar_count", 0, 32'(bus.target_count), 32'd0);
    check("ar_fault", 0, 32'(bus.fault_code), 32'd0);
    check("ar_retry", 0, 32'(bus.retry_cnt), 32'd0);
    #1 reset = 1'b0;
    step();
    check("ar_after", 0, 32'(bus.state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
